mem_excep_stage: RTL and testbench

EX/MEM pipeline register with memory-stage exception collection, sitting directly upstream of cp0. It registers EX results, detects misaligned data addresses, and merges them into the 32-bit exception-type vector that cp0 consumes. It drives the data SRAM port and suppresses every side effect of an excepting instruction. Because cp0 asserts its registered flush one cycle after sampling an exception, this block also kills the single instruction that follows into MEM during that gap.

---
 rtl/mem_excep_stage_pkg.sv | 60 ++++++
 rtl/mem_align_check.sv | 43 ++++
 rtl/mem_excep_stage.sv | 144 ++++++++++++++
 tb/tb_mem_excep_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_excep_stage_pkg.sv
// Shared definitions for the EX/MEM stage with memory-exception collection.
// Holds the bus widths, exception-vector bit positions, memory op encodings,
// the stage FSM states and the packed EX/MEM pipeline register layout.
package mem_excep_stage_pkg;

  localparam int unsigned InstBus      = 32;
  localparam int unsigned Cp0AddrBus   = 5;
  localparam int unsigned ExcepTypeBus = 32;
  localparam int unsigned MemOpBus     = 4;

  // Exception-type vector bit positions
  localparam int unsigned ExcepAdelIf = 31;
  localparam int unsigned ExcepRi     = 30;
  localparam int unsigned ExcepOv     = 29;
  localparam int unsigned ExcepBp     = 28;
  localparam int unsigned ExcepSys    = 27;
  localparam int unsigned ExcepAdel   = 26;
  localparam int unsigned ExcepAdes   = 25;
  localparam int unsigned ExcepEret   = 0;

  // Bits that may legitimately arrive from upstream stages
  localparam logic [ExcepTypeBus-1:0] ExcepUpstreamMask =
      (ExcepTypeBus'(1) << ExcepAdelIf) | (ExcepTypeBus'(1) << ExcepRi) |
      (ExcepTypeBus'(1) << ExcepOv)     | (ExcepTypeBus'(1) << ExcepBp) |
      (ExcepTypeBus'(1) << ExcepSys)    | (ExcepTypeBus'(1) << ExcepEret);

  typedef enum logic [MemOpBus-1:0] {
    MemOpNone = 4'd0,
    MemOpLb   = 4'd1,
    MemOpLbu  = 4'd2,
    MemOpLh   = 4'd3,
    MemOpLhu  = 4'd4,
    MemOpLw   = 4'd5,
    MemOpSb   = 4'd6,
    MemOpSh   = 4'd7,
    MemOpSw   = 4'd8
  } mem_op_e;

  typedef enum logic {
    MsRun   = 1'b0,
    MsDrain = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                    valid;
    logic [InstBus-1:0]      pc;
    logic [ExcepTypeBus-1:0] excep;
    logic                    in_delayslot;
    logic [MemOpBus-1:0]     mem_op;
    logic [31:0]             mem_addr;
    logic [31:0]             mem_wdata;
    logic                    cp0_we;
    logic [Cp0AddrBus-1:0]   cp0_waddr;
    logic [31:0]             cp0_wdata;
    logic                    reg_we;
    logic [4:0]              reg_waddr;
    logic [31:0]             reg_wdata;
  } ex_mem_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational data-address alignment checker and store formatter.
//   mem_op_i     : registered memory op
//   addr_lo_i    : low two bits of the effective address
//   wdata_i      : raw store data
//   align_bits_o : [1] load/fetch-side AdEL, [0] store-side AdES
//   wen_o        : byte write enables (loads and non-memory ops give 0)
//   wdata_o      : store data replicated across the lanes
module mem_align_check
  import mem_excep_stage_pkg::*;
(
  input  logic [MemOpBus-1:0] mem_op_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [31:0]         wdata_i,
  output logic [1:0]          align_bits_o,
  output logic [3:0]          wen_o,
  output logic [31:0]         wdata_o
);

  always_comb begin
    align_bits_o = 2'b00;
    wen_o        = 4'b0000;
    wdata_o      = wdata_i;
    case (mem_op_i)
      MemOpLh, MemOpLhu: align_bits_o[1] = addr_lo_i[0];
      MemOpLw:           align_bits_o[1] = |addr_lo_i;
      MemOpSb: begin
        wen_o   = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      MemOpSh: begin
        align_bits_o[0] = addr_lo_i[0];
        wen_o           = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o         = {2{wdata_i[15:0]}};
      end
      MemOpSw: begin
        align_bits_o[0] = |addr_lo_i;
        wen_o           = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_excep_stage.sv
// EX/MEM pipeline register with memory-stage exception collection.
// Registers EX results, flags misaligned data accesses, merges them into the
// exception-type vector for cp0, drives the data SRAM port and suppresses all
// side effects of an excepting instruction. After an exception the stage
// enters a drain state that masks the following instruction until cp0's
// registered flush arrives one cycle later.
//   clk, rst (async, active-low)     : clock and reset
//   stall_i / flush_i                : hold / invalidate the register
//   ex_*                             : EX-stage results
//   excep_type_o, excep_addr_o,
//   pc_o, in_delayslot_o             : exception report to cp0
//   cp0_we_o/waddr_o/wdata_o         : mtc0 write port
//   data_sram_*                      : data SRAM request
//   reg_we_o/waddr_o/wdata_o, mem_op_o : to MEM/WB
module mem_excep_stage
  import mem_excep_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    ex_valid_i,
  input  logic [InstBus-1:0]      ex_pc_i,
  input  logic [ExcepTypeBus-1:0] ex_excep_i,
  input  logic                    ex_in_delayslot_i,
  input  logic [MemOpBus-1:0]     ex_mem_op_i,
  input  logic [31:0]             ex_mem_addr_i,
  input  logic [31:0]             ex_mem_wdata_i,
  input  logic                    ex_cp0_we_i,
  input  logic [Cp0AddrBus-1:0]   ex_cp0_waddr_i,
  input  logic [31:0]             ex_cp0_wdata_i,
  input  logic                    ex_reg_we_i,
  input  logic [4:0]              ex_reg_waddr_i,
  input  logic [31:0]             ex_reg_wdata_i,
  output logic [ExcepTypeBus-1:0] excep_type_o,
  output logic [31:0]             excep_addr_o,
  output logic [InstBus-1:0]      pc_o,
  output logic                    in_delayslot_o,
  output logic                    cp0_we_o,
  output logic [Cp0AddrBus-1:0]   cp0_waddr_o,
  output logic [31:0]             cp0_wdata_o,
  output logic                    data_sram_en_o,
  output logic [3:0]              data_sram_wen_o,
  output logic [31:0]             data_sram_addr_o,
  output logic [31:0]             data_sram_wdata_o,
  output logic                    reg_we_o,
  output logic [4:0]              reg_waddr_o,
  output logic [31:0]             reg_wdata_o,
  output logic [MemOpBus-1:0]     mem_op_o
);

  ex_mem_t    reg_q, reg_d;
  mem_state_e state_q, state_d;

  logic                    valid_eff;
  logic                    excep_any;
  logic                    sram_en;
  logic [1:0]              align_bits;
  logic [3:0]              wen;
  logic [31:0]             wdata_rep;
  logic [ExcepTypeBus-1:0] excep_type;

  mem_align_check u_align (
    .mem_op_i     (reg_q.mem_op),
    .addr_lo_i    (reg_q.mem_addr[1:0]),
    .wdata_i      (reg_q.mem_wdata),
    .align_bits_o (align_bits),
    .wen_o        (wen),
    .wdata_o      (wdata_rep)
  );

  // Pipeline register next state; flush beats stall
  always_comb begin
    reg_d = reg_q;
    if (flush_i) begin
      reg_d.valid = 1'b0;
    end else if (!stall_i) begin
      reg_d.valid        = ex_valid_i;
      reg_d.pc           = ex_pc_i;
      reg_d.excep        = ex_excep_i;
      reg_d.in_delayslot = ex_in_delayslot_i;
      reg_d.mem_op       = ex_mem_op_i;
      reg_d.mem_addr     = ex_mem_addr_i;
      reg_d.mem_wdata    = ex_mem_wdata_i;
      reg_d.cp0_we       = ex_cp0_we_i;
      reg_d.cp0_waddr    = ex_cp0_waddr_i;
      reg_d.cp0_wdata    = ex_cp0_wdata_i;
      reg_d.reg_we       = ex_reg_we_i;
      reg_d.reg_waddr    = ex_reg_waddr_i;
      reg_d.reg_wdata    = ex_reg_wdata_i;
    end
  end

  // Exception collection and side-effect gating
  always_comb begin
    valid_eff  = reg_q.valid & (state_q == MsRun);
    excep_type = '0;
    if (valid_eff) begin
      excep_type = (reg_q.excep & ExcepUpstreamMask) |
                   {5'b0, align_bits, 25'b0};
    end
    excep_any = |excep_type;
    sram_en   = valid_eff & (reg_q.mem_op != MemOpNone) & ~excep_any;
  end

  // Drain covers the cycle between reporting an exception and cp0's flush
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MsRun:   if (excep_any && !flush_i) state_d = MsDrain;
      MsDrain: if (flush_i) state_d = MsRun;
      default: state_d = MsRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q   <= '0;
      state_q <= MsRun;
    end else begin
      reg_q   <= reg_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    excep_type_o      = excep_type;
    excep_addr_o      = reg_q.mem_addr;
    pc_o              = reg_q.pc;
    in_delayslot_o    = reg_q.in_delayslot;
    cp0_we_o          = reg_q.cp0_we & valid_eff & ~excep_any;
    cp0_waddr_o       = reg_q.cp0_waddr;
    cp0_wdata_o       = reg_q.cp0_wdata;
    data_sram_en_o    = sram_en;
    data_sram_wen_o   = sram_en ? wen : 4'b0000;
    data_sram_addr_o  = reg_q.mem_addr;
    data_sram_wdata_o = wdata_rep;
    reg_we_o          = reg_q.reg_we & valid_eff & ~excep_any;
    reg_waddr_o       = reg_q.reg_waddr;
    reg_wdata_o       = reg_q.reg_wdata;
    mem_op_o          = reg_q.mem_op;
  end

endmodule

// File: tb/tb_mem_excep_stage.sv
module tb_mem_excep_stage;
  import mem_excep_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i, flush_i, ex_valid_i, ex_in_delayslot_i;
  logic [31:0] ex_pc_i, ex_excep_i, ex_mem_addr_i, ex_mem_wdata_i;
  logic [3:0]  ex_mem_op_i;
  logic        ex_cp0_we_i, ex_reg_we_i;
  logic [4:0]  ex_cp0_waddr_i, ex_reg_waddr_i;
  logic [31:0] ex_cp0_wdata_i, ex_reg_wdata_i;

  logic [31:0] excep_type_o, excep_addr_o, pc_o, cp0_wdata_o;
  logic        in_delayslot_o, cp0_we_o, data_sram_en_o, reg_we_o;
  logic [4:0]  cp0_waddr_o, reg_waddr_o;
  logic [3:0]  data_sram_wen_o, mem_op_o;
  logic [31:0] data_sram_addr_o, data_sram_wdata_o, reg_wdata_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_excep_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .ex_valid_i        (ex_valid_i),
    .ex_pc_i           (ex_pc_i),
    .ex_excep_i        (ex_excep_i),
    .ex_in_delayslot_i (ex_in_delayslot_i),
    .ex_mem_op_i       (ex_mem_op_i),
    .ex_mem_addr_i     (ex_mem_addr_i),
    .ex_mem_wdata_i    (ex_mem_wdata_i),
    .ex_cp0_we_i       (ex_cp0_we_i),
    .ex_cp0_waddr_i    (ex_cp0_waddr_i),
    .ex_cp0_wdata_i    (ex_cp0_wdata_i),
    .ex_reg_we_i       (ex_reg_we_i),
    .ex_reg_waddr_i    (ex_reg_waddr_i),
    .ex_reg_wdata_i    (ex_reg_wdata_i),
    .excep_type_o      (excep_type_o),
    .excep_addr_o      (excep_addr_o),
    .pc_o              (pc_o),
    .in_delayslot_o    (in_delayslot_o),
    .cp0_we_o          (cp0_we_o),
    .cp0_waddr_o       (cp0_waddr_o),
    .cp0_wdata_o       (cp0_wdata_o),
    .data_sram_en_o    (data_sram_en_o),
    .data_sram_wen_o   (data_sram_wen_o),
    .data_sram_addr_o  (data_sram_addr_o),
    .data_sram_wdata_o (data_sram_wdata_o),
    .reg_we_o          (reg_we_o),
    .reg_waddr_o       (reg_waddr_o),
    .reg_wdata_o       (reg_wdata_o),
    .mem_op_o          (mem_op_o)
  );

  // Reference model: the instruction currently held in MEM plus a flag for
  // "an exception was reported and cp0's flush has not yet arrived".
  logic        m_valid, m_drain, m_ds, m_cp0_we, m_reg_we;
  logic [31:0] m_pc, m_excep, m_addr, m_wdata, m_cp0_wdata, m_reg_wdata;
  logic [3:0]  m_op;
  logic [4:0]  m_cp0_waddr, m_reg_waddr;

  function automatic logic [31:0] m_align(input logic [3:0] op, input logic [31:0] addr);
    if ((op == MemOpLh || op == MemOpLhu) && (addr % 2 != 0)) return 32'h0400_0000;
    if (op == MemOpLw && (addr % 4 != 0)) return 32'h0400_0000;
    if (op == MemOpSh && (addr % 2 != 0)) return 32'h0200_0000;
    if (op == MemOpSw && (addr % 4 != 0)) return 32'h0200_0000;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_excep_type();
    if (m_valid && !m_drain) return m_excep | m_align(m_op, m_addr);
    return 32'h0;
  endfunction

  task automatic idle_inputs();
    ex_valid_i = 0; ex_pc_i = 0; ex_excep_i = 0; ex_in_delayslot_i = 0;
    ex_mem_op_i = MemOpNone; ex_mem_addr_i = 0; ex_mem_wdata_i = 0;
    ex_cp0_we_i = 0; ex_cp0_waddr_i = 0; ex_cp0_wdata_i = 0;
    ex_reg_we_i = 0; ex_reg_waddr_i = 0; ex_reg_wdata_i = 0;
  endtask

  task automatic set_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    idle_inputs();
    ex_valid_i = 1; ex_mem_op_i = op; ex_mem_addr_i = addr; ex_mem_wdata_i = wd;
    ex_pc_i = 32'hBFC0_0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Excepting instruction is in MEM: let cp0 flush it and return to idle
  task automatic recover();
    idle_inputs();
    tick();
    flush_i = 1;
    tick();
    flush_i = 0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (excep_type_o !== 32'h0) begin bad++; $display("FAIL reset_excep got=%h exp=0", excep_type_o); end
    total++; if (data_sram_en_o !== 1'b0 || data_sram_wen_o !== 4'h0) begin
      bad++; $display("FAIL reset_sram got en=%b wen=%h exp 0/0", data_sram_en_o, data_sram_wen_o); end
    total++; if (reg_we_o !== 1'b0 || cp0_we_o !== 1'b0) begin
      bad++; $display("FAIL reset_we got reg=%b cp0=%b exp 0/0", reg_we_o, cp0_we_o); end
    total++; if (data_sram_addr_o !== 32'h0 || excep_addr_o !== 32'h0 || pc_o !== 32'h0) begin
      bad++; $display("FAIL reset_addr got %h %h %h exp 0", data_sram_addr_o, excep_addr_o, pc_o); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_sw();
    set_mem(MemOpSw, 32'h8000_0004, 32'h1234_5678);
    tick();
    idle_inputs();
    total++; if (data_sram_en_o !== 1'b1 || data_sram_wen_o !== 4'hF) begin
      bad++; $display("FAIL sw_en got en=%b wen=%h exp 1/f", data_sram_en_o, data_sram_wen_o); end
    total++; if (data_sram_wdata_o !== 32'h1234_5678 || data_sram_addr_o !== 32'h8000_0004) begin
      bad++; $display("FAIL sw_data got %h@%h exp 12345678@80000004", data_sram_wdata_o, data_sram_addr_o); end
    total++; if (excep_type_o !== 32'h0) begin bad++; $display("FAIL sw_excep got=%h exp=0", excep_type_o); end
    tick();
  endtask

  task automatic test_sb();
    set_mem(MemOpSb, 32'h8000_0003, 32'h0000_00AB);
    tick();
    idle_inputs();
    total++; if (data_sram_wen_o !== 4'b1000) begin bad++; $display("FAIL sb_wen got=%b exp=1000", data_sram_wen_o); end
    total++; if (data_sram_wdata_o !== 32'hABAB_ABAB) begin
      bad++; $display("FAIL sb_wdata got=%h exp=ababab ab", data_sram_wdata_o); end
    tick();
  endtask

  task automatic test_lw_excep();
    set_mem(MemOpLw, 32'h8000_0002, 32'h0);
    tick();
    // Following ADD enters EX
    idle_inputs();
    ex_valid_i = 1; ex_reg_we_i = 1; ex_reg_waddr_i = 5'd3; ex_reg_wdata_i = 32'h55;
    total++; if (excep_type_o !== 32'h0400_0000) begin bad++; $display("FAIL lw_excep got=%h exp=04000000", excep_type_o); end
    total++; if (excep_addr_o !== 32'h8000_0002) begin bad++; $display("FAIL lw_addr got=%h exp=80000002", excep_addr_o); end
    total++; if (data_sram_en_o !== 1'b0) begin bad++; $display("FAIL lw_en got=%b exp=0", data_sram_en_o); end
    tick();
    idle_inputs();
    flush_i = 1;
    total++; if (reg_we_o !== 1'b0 || excep_type_o !== 32'h0) begin
      bad++; $display("FAIL add_masked got we=%b excep=%h exp 0/0", reg_we_o, excep_type_o); end
    tick();
    flush_i = 0;
    total++; if (reg_we_o !== 1'b0 || data_sram_en_o !== 1'b0) begin
      bad++; $display("FAIL post_flush got we=%b en=%b exp 0/0", reg_we_o, data_sram_en_o); end
    // Back in RUN: a store must go through
    set_mem(MemOpSw, 32'h8000_0010, 32'hCAFE_F00D);
    tick();
    idle_inputs();
    total++; if (data_sram_en_o !== 1'b1 || data_sram_wen_o !== 4'hF) begin
      bad++; $display("FAIL run_after_flush got en=%b wen=%h exp 1/f", data_sram_en_o, data_sram_wen_o); end
    tick();
  endtask

  task automatic test_sh_dslot();
    set_mem(MemOpSh, 32'h8000_0001, 32'h0000_BEEF);
    ex_pc_i = 32'hBFC0_0104; ex_in_delayslot_i = 1;
    tick();
    total++; if (excep_type_o !== 32'h0200_0000) begin bad++; $display("FAIL sh_excep got=%h exp=02000000", excep_type_o); end
    total++; if (in_delayslot_o !== 1'b1 || pc_o !== 32'hBFC0_0104) begin
      bad++; $display("FAIL sh_ds got ds=%b pc=%h exp 1/bfc00104", in_delayslot_o, pc_o); end
    total++; if (data_sram_wen_o !== 4'h0 || data_sram_en_o !== 1'b0) begin
      bad++; $display("FAIL sh_wen got wen=%h en=%b exp 0/0", data_sram_wen_o, data_sram_en_o); end
    recover();
  endtask

  task automatic test_stall();
    set_mem(MemOpLw, 32'h8000_0008, 32'h0);
    ex_reg_we_i = 1; ex_reg_waddr_i = 5'd8; ex_reg_wdata_i = 32'h0;
    tick();
    stall_i = 1;
    set_mem(MemOpSw, 32'h9000_0000, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (data_sram_en_o !== 1'b1 || data_sram_wen_o !== 4'h0 || data_sram_addr_o !== 32'h8000_0008 ||
          reg_we_o !== 1'b1 || reg_waddr_o !== 5'd8 || excep_type_o !== 32'h0) begin
        bad++;
        $display("FAIL stall_hold%0d got en=%b wen=%h addr=%h we=%b exp 1/0/80000008/1",
                 i, data_sram_en_o, data_sram_wen_o, data_sram_addr_o, reg_we_o);
      end
    end
    flush_i = 1;
    tick();
    total++; if (data_sram_en_o !== 1'b0 || reg_we_o !== 1'b0) begin
      bad++; $display("FAIL stall_flush got en=%b we=%b exp 0/0", data_sram_en_o, reg_we_o); end
    flush_i = 0; stall_i = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_drain();
    set_mem(MemOpLw, 32'h8000_0003, 32'h0);
    tick();
    idle_inputs();
    ex_valid_i = 1; ex_reg_we_i = 1; ex_reg_waddr_i = 5'd1;
    tick();  // now draining
    idle_inputs();
    #2;
    rst = 0;
    #1;
    total++; if (excep_type_o !== 32'h0 || data_sram_en_o !== 1'b0 || reg_we_o !== 1'b0 ||
                 data_sram_addr_o !== 32'h0 || pc_o !== 32'h0) begin
      bad++; $display("FAIL rst_drain got excep=%h en=%b we=%b addr=%h exp zeros",
                      excep_type_o, data_sram_en_o, reg_we_o, data_sram_addr_o); end
    rst = 1;
    set_mem(MemOpSw, 32'h8000_0020, 32'h0BAD_F00D);
    tick();
    idle_inputs();
    total++; if (data_sram_en_o !== 1'b1 || data_sram_wen_o !== 4'hF || data_sram_wdata_o !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL rst_then_sw got en=%b wen=%h wd=%h exp 1/f/0badf00d",
                      data_sram_en_o, data_sram_wen_o, data_sram_wdata_o); end
    tick();
  endtask

  task automatic test_random();
    int          bits [6] = '{31, 30, 29, 28, 27, 0};
    logic [31:0] et, ewd;
    logic [3:0]  ewen;
    logic        veff, any, en;
    // Synchronise model with a fresh reset
    @(negedge clk);
    rst = 0; #1; rst = 1;
    stall_i = 0; flush_i = 0;
    m_valid = 0; m_drain = 0; m_ds = 0; m_cp0_we = 0; m_reg_we = 0; m_pc = 0; m_excep = 0;
    m_addr = 0; m_wdata = 0; m_cp0_wdata = 0; m_reg_wdata = 0; m_op = 0; m_cp0_waddr = 0; m_reg_waddr = 0;
    for (int c = 0; c < 600; c++) begin
      ex_valid_i = ($urandom_range(0, 5) != 0);
      ex_pc_i = $urandom(); ex_in_delayslot_i = 1'($urandom_range(0, 1));
      ex_excep_i = ($urandom_range(0, 7) == 0) ? (32'h1 << bits[$urandom_range(0, 5)]) : 32'h0;
      ex_mem_op_i = 4'($urandom_range(0, 8));
      ex_mem_addr_i = $urandom(); ex_mem_wdata_i = $urandom();
      ex_cp0_we_i = 1'($urandom_range(0, 1)); ex_cp0_waddr_i = 5'($urandom()); ex_cp0_wdata_i = $urandom();
      ex_reg_we_i = 1'($urandom_range(0, 1)); ex_reg_waddr_i = 5'($urandom()); ex_reg_wdata_i = $urandom();
      stall_i = ($urandom_range(0, 4) == 0);
      // cp0 flushes in the cycle after an exception, plus occasional interrupts
      flush_i = m_drain || ($urandom_range(0, 15) == 0);
      any = (m_excep_type() != 0);
      if (!m_drain && any && !flush_i) m_drain = 1;
      else if (m_drain && flush_i) m_drain = 0;
      if (flush_i) m_valid = 0;
      else if (!stall_i) begin
        m_valid = ex_valid_i; m_pc = ex_pc_i; m_excep = ex_excep_i; m_ds = ex_in_delayslot_i;
        m_op = ex_mem_op_i; m_addr = ex_mem_addr_i; m_wdata = ex_mem_wdata_i;
        m_cp0_we = ex_cp0_we_i; m_cp0_waddr = ex_cp0_waddr_i; m_cp0_wdata = ex_cp0_wdata_i;
        m_reg_we = ex_reg_we_i; m_reg_waddr = ex_reg_waddr_i; m_reg_wdata = ex_reg_wdata_i;
      end
      tick();
      veff = m_valid && !m_drain;
      et   = m_excep_type();
      any  = (et != 0);
      en   = veff && (m_op != MemOpNone) && !any;
      ewen = 4'h0; ewd = m_wdata;
      if (m_op == MemOpSb) begin ewen = 4'h1 << (m_addr % 4); ewd = m_wdata[7:0] * 32'h0101_0101; end
      if (m_op == MemOpSh) begin ewen = (m_addr % 4 >= 2) ? 4'hC : 4'h3; ewd = m_wdata[15:0] * 32'h0001_0001; end
      if (m_op == MemOpSw) ewen = 4'hF;
      if (!en) ewen = 4'h0;
      total++; if (excep_type_o !== et) begin bad++; $display("FAIL rnd_excep c=%0d got=%h exp=%h", c, excep_type_o, et); end
      total++; if (data_sram_en_o !== en || data_sram_wen_o !== ewen) begin
        bad++; $display("FAIL rnd_sram c=%0d got en=%b wen=%h exp %b/%h", c, data_sram_en_o, data_sram_wen_o, en, ewen); end
      total++; if (data_sram_wdata_o !== ewd || data_sram_addr_o !== m_addr || excep_addr_o !== m_addr) begin
        bad++; $display("FAIL rnd_data c=%0d got wd=%h a=%h exp %h/%h", c, data_sram_wdata_o, data_sram_addr_o, ewd, m_addr); end
      total++; if (reg_we_o !== (veff && !any && m_reg_we) || reg_waddr_o !== m_reg_waddr || reg_wdata_o !== m_reg_wdata) begin
        bad++; $display("FAIL rnd_reg c=%0d got we=%b a=%0d d=%h", c, reg_we_o, reg_waddr_o, reg_wdata_o); end
      total++; if (cp0_we_o !== (veff && !any && m_cp0_we) || cp0_waddr_o !== m_cp0_waddr || cp0_wdata_o !== m_cp0_wdata) begin
        bad++; $display("FAIL rnd_cp0 c=%0d got we=%b a=%0d d=%h", c, cp0_we_o, cp0_waddr_o, cp0_wdata_o); end
      total++; if (pc_o !== m_pc || in_delayslot_o !== m_ds || mem_op_o !== m_op) begin
        bad++; $display("FAIL rnd_pc c=%0d got pc=%h ds=%b op=%0d exp %h/%b/%0d", c, pc_o, in_delayslot_o, mem_op_o, m_pc, m_ds, m_op); end
    end
    stall_i = 0; flush_i = 0;
    idle_inputs();
  endtask

  initial begin
    stall_i = 0; flush_i = 0;
    idle_inputs();
    test_reset();
    tick();
    test_sw();
    test_sb();
    test_lw_excep();
    test_sh_dslot();
    test_stall();
    test_reset_in_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
